mult32x32_arb: RTL and testbench

MULT32X32_ARB -- requirements
Module: mult32x32_arb

---
 rtl/mult32x32_arb_if.sv | 36 +++
 rtl/mult32x32_arb.sv | 164 ++++++++++++++++
 tb/tb_mult32x32_arb.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mult32x32_arb_if.sv
// mult32x32_arb_if
//   Bundles the requester-side handshake and the shared-multiplier bus of
//   mult32x32_arb.
//   Requester side : req[1:0], a0/b0, a1/b1 in; gnt[1:0], done[1:0],
//                    result[63:0], err, arb_busy out.
//   Multiplier side: mult_start, mult_a, mult_b out; mult_busy,
//                    mult_product in.
//   slave  modport : the arbiter's view.
//   master modport : the environment's view (requesters plus multiplier).
interface mult32x32_arb_if;
  logic [1:0]  req;
  logic [31:0] a0;
  logic [31:0] b0;
  logic [31:0] a1;
  logic [31:0] b1;
  logic [1:0]  gnt;
  logic [1:0]  done;
  logic [63:0] result;
  logic        err;
  logic        arb_busy;
  logic        mult_start;
  logic [31:0] mult_a;
  logic [31:0] mult_b;
  logic        mult_busy;
  logic [63:0] mult_product;

  modport slave (
    input  req, a0, b0, a1, b1, mult_busy, mult_product,
    output gnt, done, result, err, arb_busy, mult_start, mult_a, mult_b
  );

  modport master (
    output req, a0, b0, a1, b1, mult_busy, mult_product,
    input  gnt, done, result, err, arb_busy, mult_start, mult_a, mult_b
  );
endinterface

// File: rtl/mult32x32_arb.sv
// mult32x32_arb
//   Round-robin arbiter that lets two requesters share one external
//   32x32 multiplier. It latches the winner's operands, pulses mult_start,
//   follows mult_busy high and then low, and returns the product together
//   with a one-cycle done pulse. A saturating watchdog aborts a wait state
//   that lasts too long; the abort is reported through err.
//   Ports: clk (rising edge), reset (asynchronous, active high), and
//   bus (mult32x32_arb_if.slave). Every output is driven from a flop.
module mult32x32_arb #(
  parameter int WDOG_MAX = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  mult32x32_arb_if.slave        bus
);

  localparam int CW = (WDOG_MAX < 1) ? 1 : $clog2(WDOG_MAX + 1);
  localparam logic [CW-1:0] WDOG_LIM = CW'(WDOG_MAX);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT_HI = 3'd2,
    WAIT_LO = 3'd3,
    RESP    = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  done_q, done_d;
  logic [63:0] result_q, result_d;
  logic        err_q, err_d;
  logic        mult_start_q, mult_start_d;
  logic [31:0] mult_a_q, mult_a_d;
  logic [31:0] mult_b_q, mult_b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        arb_busy_q, arb_busy_d;
  // last_q: 1 means port 1 was served last, so port 0 wins the next tie.
  logic        last_q, last_d;
  logic        win_s;
  logic [CW-1:0] cnt_inc_s;

  // Next-state, grant selection, operand latching and watchdog logic.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    done_d       = 2'b00;
    result_d     = result_q;
    err_d        = 1'b0;
    mult_start_d = 1'b0;
    mult_a_d     = mult_a_q;
    mult_b_d     = mult_b_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    // Port 1 wins when it is alone, or on a tie when port 0 was served last.
    win_s        = bus.req[1] & (~bus.req[0] | ~last_q);
    // Saturating increment: the counter never wraps past WDOG_MAX.
    if (cnt_q == WDOG_LIM) begin
      cnt_inc_s = cnt_q;
    end else begin
      cnt_inc_s = cnt_q + CW'(1);
    end

    case (state_q)
      IDLE: begin
        if (bus.req != 2'b00) begin
          gnt_d        = win_s ? 2'b10 : 2'b01;
          last_d       = win_s;
          mult_a_d     = win_s ? bus.a1 : bus.a0;
          mult_b_d     = win_s ? bus.b1 : bus.b0;
          mult_start_d = 1'b1;
          state_d      = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        cnt_d   = {CW{1'b0}};
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (bus.mult_busy) begin
          cnt_d   = {CW{1'b0}};
          state_d = WAIT_LO;
        end else begin
          cnt_d = cnt_inc_s;
          if (cnt_inc_s == WDOG_LIM) begin
            err_d   = 1'b1;
            done_d  = gnt_q;
            state_d = RESP;
          end else begin
            state_d = WAIT_HI;
          end
        end
      end
      WAIT_LO: begin
        if (!bus.mult_busy) begin
          result_d = bus.mult_product;
          err_d    = 1'b0;
          done_d   = gnt_q;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_inc_s;
          if (cnt_inc_s == WDOG_LIM) begin
            err_d   = 1'b1;
            done_d  = gnt_q;
            state_d = RESP;
          end else begin
            state_d = WAIT_LO;
          end
        end
      end
      RESP: begin
        gnt_d   = 2'b00;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = 2'b00;
        state_d = IDLE;
      end
    endcase

    arb_busy_d = (state_d != IDLE);
  end

  // State and output registers; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      gnt_q        <= 2'b00;
      done_q       <= 2'b00;
      result_q     <= 64'd0;
      err_q        <= 1'b0;
      mult_start_q <= 1'b0;
      mult_a_q     <= 32'd0;
      mult_b_q     <= 32'd0;
      cnt_q        <= {CW{1'b0}};
      arb_busy_q   <= 1'b0;
      last_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      result_q     <= result_d;
      err_q        <= err_d;
      mult_start_q <= mult_start_d;
      mult_a_q     <= mult_a_d;
      mult_b_q     <= mult_b_d;
      cnt_q        <= cnt_d;
      arb_busy_q   <= arb_busy_d;
      last_q       <= last_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.done       = done_q;
  assign bus.result     = result_q;
  assign bus.err        = err_q;
  assign bus.arb_busy   = arb_busy_q;
  assign bus.mult_start = mult_start_q;
  assign bus.mult_a     = mult_a_q;
  assign bus.mult_b     = mult_b_q;

endmodule

// File: tb/tb_mult32x32_arb.sv
// tb_mult32x32_arb
//   Directed bench for mult32x32_arb with a small behavioural multiplier
//   that stays busy for 8 cycles after each start (or never goes busy
//   while mult_stall is set).
module tb_mult32x32_arb;

  logic clk;
  logic reset;
  logic mult_stall;
  int   busy_cnt;
  logic [63:0] prod_r;
  int   n_checks;
  int   n_errors;

  mult32x32_arb_if bus ();

  mult32x32_arb #(.WDOG_MAX(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural multiplier: 8 busy cycles, product ready when busy drops.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_cnt <= 0;
      prod_r   <= 64'd0;
    end else if (bus.mult_start && !mult_stall) begin
      busy_cnt <= 8;
      prod_r   <= {32'd0, bus.mult_a} * {32'd0, bus.mult_b};
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  assign bus.mult_busy    = (busy_cnt != 0);
  assign bus.mult_product = prod_r;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the next done pulse; optional mid-operation
  // operand change on a0 at cycle chg_n and req drop at cycle drop_n.
  task automatic run_wait(input int chg_n, input int drop_n,
                          output int lat, output logic [1:0] dn,
                          output int starts, output logic [1:0] g1,
                          output logic busy1, output logic [31:0] ma);
    lat = 0; dn = 2'b00; starts = 0; g1 = 2'b00; busy1 = 1'b0; ma = 32'd0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.mult_start) starts++;
      if (n == 1) begin
        g1    = bus.gnt;
        busy1 = bus.arb_busy;
      end
      if (n == chg_n) bus.a0 = 32'd100;
      if (n == drop_n) bus.req = 2'b00;
      if (bus.done != 2'b00) begin
        lat = n;
        dn  = bus.done;
        ma  = bus.mult_a;
        break;
      end
    end
    check_val("done_seen", 64'(lat != 0), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_gnt"},    64'(bus.gnt),        64'd0);
    check_val({tag, "_done"},   64'(bus.done),       64'd0);
    check_val({tag, "_err"},    64'(bus.err),        64'd0);
    check_val({tag, "_result"}, bus.result,          64'd0);
    check_val({tag, "_start"},  64'(bus.mult_start), 64'd0);
    check_val({tag, "_ma"},     64'(bus.mult_a),     64'd0);
    check_val({tag, "_mb"},     64'(bus.mult_b),     64'd0);
    check_val({tag, "_busy"},   64'(bus.arb_busy),   64'd0);
  endtask

  initial begin
    int          lat;
    int          starts;
    int          done_cnt;
    logic [1:0]  dn;
    logic [1:0]  g1;
    logic        busy1;
    logic [31:0] ma;

    n_checks   = 0;
    n_errors   = 0;
    reset      = 1'b1;
    mult_stall = 1'b0;
    bus.req    = 2'b00;
    bus.a0     = 32'd0;
    bus.b0     = 32'd0;
    bus.a1     = 32'd0;
    bus.b1     = 32'd0;

    // Reset state.
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_rel");

    // Single operation: 3 * 5 on port 0.
    bus.a0 = 32'h0000_0003;
    bus.b0 = 32'h0000_0005;
    bus.req = 2'b01;
    run_wait(0, 0, lat, dn, starts, g1, busy1, ma);
    check_val("single_gnt",    64'(g1),     64'h1);
    check_val("single_abusy",  64'(busy1),  64'h1);
    check_val("single_starts", 64'(starts), 64'd1);
    check_val("single_lat",    64'(lat),    64'd11);
    check_val("single_done",   64'(dn),     64'h1);
    check_val("single_result", bus.result,  64'd15);
    check_val("single_err",    64'(bus.err), 64'd0);
    bus.req = 2'b00;
    repeat (2) @(negedge clk);
    check_val("idle_abusy", 64'(bus.arb_busy), 64'd0);
    check_val("idle_gnt",   64'(bus.gnt),      64'd0);

    // Maximum operands on port 1.
    bus.a1 = 32'hFFFF_FFFF;
    bus.b1 = 32'hFFFF_FFFF;
    bus.req = 2'b10;
    run_wait(0, 0, lat, dn, starts, g1, busy1, ma);
    check_val("max_gnt",    64'(g1),    64'h2);
    check_val("max_done",   64'(dn),    64'h2);
    check_val("max_lat",    64'(lat),   64'd11);
    check_val("max_result", bus.result, 64'hFFFF_FFFE_0000_0001);
    bus.req = 2'b00;
    @(negedge clk);

    // Tie from reset, held continuously: 0,1,0,1.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.a0 = 32'd2;
    bus.b0 = 32'd7;
    bus.a1 = 32'd3;
    bus.b1 = 32'd9;
    bus.req = 2'b11;
    run_wait(0, 0, lat, dn, starts, g1, busy1, ma);
    check_val("tie1_done",   64'(dn),    64'h1);
    check_val("tie1_result", bus.result, 64'd14);
    run_wait(0, 0, lat, dn, starts, g1, busy1, ma);
    check_val("tie2_done",   64'(dn),     64'h2);
    check_val("tie2_lat",    64'(lat),    64'd12);
    check_val("tie2_starts", 64'(starts), 64'd1);
    check_val("tie2_result", bus.result,  64'd27);
    run_wait(0, 0, lat, dn, starts, g1, busy1, ma);
    check_val("tie3_done",   64'(dn),    64'h1);
    run_wait(0, 0, lat, dn, starts, g1, busy1, ma);
    check_val("tie4_done",   64'(dn),    64'h2);
    check_val("tie4_result", bus.result, 64'd27);
    bus.req = 2'b00;
    @(negedge clk);

    // Watchdog abort: multiplier never goes busy.
    mult_stall = 1'b1;
    bus.a0 = 32'd4;
    bus.b0 = 32'd4;
    bus.req = 2'b01;
    run_wait(0, 0, lat, dn, starts, g1, busy1, ma);
    check_val("wdog_done",   64'(dn),      64'h1);
    check_val("wdog_err",    64'(bus.err), 64'd1);
    check_val("wdog_lat",    64'(lat),     64'd17);
    check_val("wdog_result", bus.result,   64'd27);
    bus.req = 2'b00;
    mult_stall = 1'b0;
    @(negedge clk);
    check_val("wdog_err_clr", 64'(bus.err), 64'd0);

    // Operand change after grant: a0 altered during WAIT_LO.
    bus.a0 = 32'd6;
    bus.b0 = 32'd7;
    bus.req = 2'b01;
    run_wait(5, 0, lat, dn, starts, g1, busy1, ma);
    check_val("opchg_done",   64'(dn),      64'h1);
    check_val("opchg_ma",     64'(ma),      64'd6);
    check_val("opchg_result", bus.result,   64'd42);
    check_val("opchg_err",    64'(bus.err), 64'd0);
    bus.req = 2'b00;
    @(negedge clk);

    // Granted port drops req mid-operation: still completes.
    bus.a1 = 32'd5;
    bus.b1 = 32'd5;
    bus.req = 2'b10;
    run_wait(0, 4, lat, dn, starts, g1, busy1, ma);
    check_val("drop_done",   64'(dn),    64'h2);
    check_val("drop_lat",    64'(lat),   64'd11);
    check_val("drop_result", bus.result, 64'd25);
    @(negedge clk);

    // Reset during WAIT_LO abandons the operation.
    bus.a0 = 32'd8;
    bus.b0 = 32'd8;
    bus.req = 2'b01;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
    end
    check_val("pre_rst_busy", 64'(bus.arb_busy), 64'd1);
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    check_val("midrst_done2", 64'(bus.done), 64'd0);
    reset = 1'b0;
    bus.req = 2'b00;
    done_cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done != 2'b00) done_cnt++;
    end
    check_val("midrst_nodone", 64'(done_cnt), 64'd0);
    bus.a1 = 32'd9;
    bus.b1 = 32'd9;
    bus.req = 2'b10;
    run_wait(0, 0, lat, dn, starts, g1, busy1, ma);
    check_val("post_rst_done",   64'(dn),    64'h2);
    check_val("post_rst_lat",    64'(lat),   64'd11);
    check_val("post_rst_result", bus.result, 64'd81);
    bus.req = 2'b00;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
